memwb_skid_stage: RTL and testbench
===================================

Name: memwb_skid_stage

Overview:
- Parametrised MEM→WB pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
- Carries two data words (memory read data, ALU result), a control vector (e.g. RegWrite, MemtoReg) and the write-back register address.
- Adds stall back-pressure, flush (bubble insertion) and control gating, while keeping full throughput of 1 transfer/cycle.
- Sits between the MEM stage and the register-file write port; also usable for any inter-stage boundary.

Parameters:
- DATA_W, 32: width of each data word.
- CTRL_W, 2: width of the control vector; bit 0 = RegWrite, bit 1 = MemtoReg by convention.
- ADDR_W, 5: width of the write-back register address.

Ports:
- clk_i  input  1  clock; all state updates on its rising edge.
- rst_i  input  1  synchronous reset, active-low.
- flush_i  input  1  synchronous flush; discards all held entries and the current input.
- valid_i  input  1  upstream presents a valid entry.
- ready_o  output  1  stage can accept an entry; registered.
- data0_i  input  DATA_W  data word 0 (memory read data).
- data1_i  input  DATA_W  data word 1 (ALU result).
- ctrl_i  input  CTRL_W  control vector.
- wbaddr_i  input  ADDR_W  write-back register address.
- valid_o  output  1  head entry valid.
- ready_i  input  1  downstream accepts the head entry.
- data0_o  output  DATA_W  head data word 0.
- data1_o  output  DATA_W  head data word 1.
- ctrl_o  output  CTRL_W  head control vector; zero whenever valid_o=0.
- wbaddr_o  output  ADDR_W  head write-back address.
- occ_o  output  2  occupancy: 0, 1 or 2 entries.

Behaviour:
- Priority at each posedge: reset (rst_i=0) > flush_i > normal operation.
- Reset: state EMPTY, main and skid registers cleared to 0. Resulting outputs: valid_o=0, ready_o=1, occ_o=0, data0_o/data1_o/ctrl_o/wbaddr_o=0.
- Handshake definitions:
  - push = valid_i & ready_o.
  - pop = valid_o & ready_i.
  - Payload inputs are don't-care when valid_i=0.
  - ready_o depends only on state, never combinationally on ready_i.
- Outputs are driven directly from the main register (no output muxing). valid_o = (state≠EMPTY). occ_o = 0/1/2 for EMPTY/ONE/TWO.
- State machine:
  - EMPTY:
    - push → ONE, main←input.
    - Otherwise stay.
  - ONE:
    - push & pop → ONE, main←input.
    - push & !pop → TWO, skid←input; main holds.
    - !push & pop → EMPTY, main.ctrl←0.
    - Otherwise hold.
  - TWO:
    - pop → ONE, main←skid.
    - Otherwise hold.
    - No push is possible because ready_o=0.
- ready_o: 1 in EMPTY and ONE, 0 in TWO. ready_o is registered, i.e. it reflects next-state at the posedge.
- Latency: 1 cycle from push into EMPTY to valid_o=1.
- Throughput: 1 entry/cycle sustained while ready_i=1.
- Ordering: strict FIFO; no entry is ever dropped or duplicated, except on flush or reset.
- Flush (flush_i=1, rst_i=1):
  - State → EMPTY.
  - main.ctrl and skid.ctrl ← 0; data/address contents are don't-care.
  - valid_o=0 and ready_o=1 next cycle.
  - A simultaneous push or pop in the flush cycle is ignored: the input is discarded and the head is not counted as delivered downstream.
- Control gating: ctrl_o = 0 whenever valid_o=0, so a bubble never asserts RegWrite.
- Reset mid-operation: both entries are lost and the reset values apply the following cycle. No partial transfer is allowed.
- Stall with ready_i=0 in TWO: all outputs stable and ready_o=0 for as long as the stall lasts.

Test Plan:
- Reset: rst_i=0 for 2 cycles with valid_i=1, data0_i=32'hDEADBEEF → valid_o=0, ready_o=1, occ_o=0, all outputs 0; first push after rst_i=1 appears next cycle.
- Streaming: ready_i=1, push 4 entries (data1_i=1,2,3,4; ctrl_i=2'b01; wbaddr_i=5'd8..11) back-to-back → data1_o=1,2,3,4 on consecutive cycles, each 1 cycle after its push; ready_o stays 1; occ_o=1.
- Back-pressure: ready_i=0, push A=32'h10 then B=32'h20 → occ_o=2, ready_o=0, data1_o=32'h10 held. Drive valid_i=1 with C=32'h30 → C not accepted. Raise ready_i → outputs 10, 20, then C after ready_o returns to 1; no loss or duplicate.
- Flush: with occ_o=2 holding ctrl 2'b11 and flush_i=1 coincident with a push of D → next cycle valid_o=0, ctrl_o=2'b00, occ_o=0, ready_o=1; D never appears at the outputs.
- Bubble gating: push with ctrl_i=2'b11, pop it, then valid_i=0 → ctrl_o=2'b00 while valid_o=0.
- Parameters: instantiate with DATA_W=64, CTRL_W=4, ADDR_W=6 and repeat the streaming test with data0_i=64'hFFFF_0000_1234_5678 → full-width values are preserved.

Source files
------------

// File: rtl/memwb_skid_stage.sv
// MEM->WB pipeline boundary: valid/ready stage with a two-entry skid buffer.
// The head entry lives in the main register, so outputs never go through a mux.
module memwb_skid_stage #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 2,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data0_i,
    input  logic [DATA_W-1:0] data1_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [ADDR_W-1:0] wbaddr_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data0_o,
    output logic [DATA_W-1:0] data1_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [ADDR_W-1:0] wbaddr_o,
    output logic [1:0]        occ_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                ready_q, ready_d;
    logic [DATA_W-1:0]   main_data0_q, main_data0_d, main_data1_q, main_data1_d;
    logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
    logic [ADDR_W-1:0]   main_wbaddr_q, main_wbaddr_d;
    logic [DATA_W-1:0]   skid_data0_q, skid_data0_d, skid_data1_q, skid_data1_d;
    logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
    logic [ADDR_W-1:0]   skid_wbaddr_q, skid_wbaddr_d;

    logic push, pop;

    assign push = valid_i & ready_q;
    assign pop  = (state_q != EMPTY) & ready_i;

    always_comb begin
        // NOTE: every _d gets a hold default first so no path can infer a latch.
        state_d       = state_q;
        main_data0_d  = main_data0_q;
        main_data1_d  = main_data1_q;
        main_ctrl_d   = main_ctrl_q;
        main_wbaddr_d = main_wbaddr_q;
        skid_data0_d  = skid_data0_q;
        skid_data1_d  = skid_data1_q;
        skid_ctrl_d   = skid_ctrl_q;
        skid_wbaddr_d = skid_wbaddr_q;

        if (flush_i) begin
            state_d     = EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d       = ONE;
                        main_data0_d  = data0_i;
                        main_data1_d  = data1_i;
                        main_ctrl_d   = ctrl_i;
                        main_wbaddr_d = wbaddr_i;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_data0_d  = data0_i;
                        main_data1_d  = data1_i;
                        main_ctrl_d   = ctrl_i;
                        main_wbaddr_d = wbaddr_i;
                    end else if (push) begin
                        state_d       = TWO;
                        skid_data0_d  = data0_i;
                        skid_data1_d  = data1_i;
                        skid_ctrl_d   = ctrl_i;
                        skid_wbaddr_d = wbaddr_i;
                    end else if (pop) begin
                        // Clearing ctrl on drain keeps a bubble from asserting RegWrite.
                        state_d     = EMPTY;
                        main_ctrl_d = '0;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_d       = ONE;
                        main_data0_d  = skid_data0_q;
                        main_data1_d  = skid_data1_q;
                        main_ctrl_d   = skid_ctrl_q;
                        main_wbaddr_d = skid_wbaddr_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end

        ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk_i) begin
        // NOTE: data registers are reset too, so every output reads zero after reset.
        if (!rst_i) begin
            state_q       <= EMPTY;
            ready_q       <= 1'b1;
            main_data0_q  <= '0;
            main_data1_q  <= '0;
            main_ctrl_q   <= '0;
            main_wbaddr_q <= '0;
            skid_data0_q  <= '0;
            skid_data1_q  <= '0;
            skid_ctrl_q   <= '0;
            skid_wbaddr_q <= '0;
        end else begin
            // NOTE: state flops use non-blocking assignment so all update together.
            state_q       <= state_d;
            ready_q       <= ready_d;
            main_data0_q  <= main_data0_d;
            main_data1_q  <= main_data1_d;
            main_ctrl_q   <= main_ctrl_d;
            main_wbaddr_q <= main_wbaddr_d;
            skid_data0_q  <= skid_data0_d;
            skid_data1_q  <= skid_data1_d;
            skid_ctrl_q   <= skid_ctrl_d;
            skid_wbaddr_q <= skid_wbaddr_d;
        end
    end

    assign ready_o  = ready_q;
    assign valid_o  = (state_q != EMPTY);
    assign occ_o    = state_q;
    assign data0_o  = main_data0_q;
    assign data1_o  = main_data1_q;
    assign ctrl_o   = main_ctrl_q;
    assign wbaddr_o = main_wbaddr_q;

endmodule

// File: tb/tb_memwb_skid_stage.sv
// Drives a default-width and a wide instance in lockstep against a FIFO scoreboard.
module tb_memwb_skid_stage;

    typedef struct packed {
        logic [63:0] d0;
        logic [63:0] d1;
        logic [3:0]  ctl;
        logic [5:0]  adr;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, valid_in, rdy_in;
    logic [63:0] d0, d1;
    logic [3:0]  ctl;
    logic [5:0]  adr;

    logic        n_ready, n_valid, w_ready, w_valid;
    logic [31:0] n_d0, n_d1;
    logic [1:0]  n_ctl, n_occ, w_occ;
    logic [4:0]  n_adr;
    logic [63:0] w_d0, w_d1;
    logic [3:0]  w_ctl;
    logic [5:0]  w_adr;

    int checks = 0;
    int errors = 0;
    entry_t sb[$];

    always #5 clk = ~clk;

    memwb_skid_stage dut_n (
        .clk_i(clk), .rst_i(rst_n), .flush_i(flush), .valid_i(valid_in), .ready_o(n_ready),
        .data0_i(d0[31:0]), .data1_i(d1[31:0]), .ctrl_i(ctl[1:0]), .wbaddr_i(adr[4:0]),
        .valid_o(n_valid), .ready_i(rdy_in), .data0_o(n_d0), .data1_o(n_d1),
        .ctrl_o(n_ctl), .wbaddr_o(n_adr), .occ_o(n_occ)
    );

    memwb_skid_stage #(.DATA_W(64), .CTRL_W(4), .ADDR_W(6)) dut_w (
        .clk_i(clk), .rst_i(rst_n), .flush_i(flush), .valid_i(valid_in), .ready_o(w_ready),
        .data0_i(d0), .data1_i(d1), .ctrl_i(ctl), .wbaddr_i(adr),
        .valid_o(w_valid), .ready_i(rdy_in), .data0_o(w_d0), .data1_o(w_d1),
        .ctrl_o(w_ctl), .wbaddr_o(w_adr), .occ_o(w_occ)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compares both instances against the scoreboard's idea of occupancy and head.
    task automatic check_outputs(input string tag);
        int cnt;
        cnt = sb.size();
        chk({tag, " n_valid"}, 64'(n_valid), 64'(cnt != 0));
        chk({tag, " n_ready"}, 64'(n_ready), 64'(cnt != 2));
        chk({tag, " n_occ"},   64'(n_occ),   64'(cnt));
        chk({tag, " w_valid"}, 64'(w_valid), 64'(cnt != 0));
        chk({tag, " w_ready"}, 64'(w_ready), 64'(cnt != 2));
        chk({tag, " w_occ"},   64'(w_occ),   64'(cnt));
        if (cnt != 0) begin
            chk({tag, " n_d0"},  64'(n_d0),  64'(sb[0].d0[31:0]));
            chk({tag, " n_d1"},  64'(n_d1),  64'(sb[0].d1[31:0]));
            chk({tag, " n_ctl"}, 64'(n_ctl), 64'(sb[0].ctl[1:0]));
            chk({tag, " n_adr"}, 64'(n_adr), 64'(sb[0].adr[4:0]));
            chk({tag, " w_d0"},  w_d0,       sb[0].d0);
            chk({tag, " w_d1"},  w_d1,       sb[0].d1);
            chk({tag, " w_ctl"}, 64'(w_ctl), 64'(sb[0].ctl));
            chk({tag, " w_adr"}, 64'(w_adr), 64'(sb[0].adr));
        end else begin
            chk({tag, " n_bubble_ctl"}, 64'(n_ctl), 64'd0);
            chk({tag, " w_bubble_ctl"}, 64'(w_ctl), 64'd0);
        end
    endtask

    // Checks the current outputs, updates the scoreboard for this edge, then advances.
    task automatic cycle(input string tag);
        logic do_push, do_pop;
        entry_t e;
        check_outputs(tag);
        do_pop  = (sb.size() != 0) && rdy_in;
        do_push = valid_in && (sb.size() != 2);
        if (flush) begin
            sb.delete();
        end else begin
            if (do_pop) void'(sb.pop_front());
            if (do_push) begin
                e = '{d0: d0, d1: d1, ctl: ctl, adr: adr};
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] a0, input logic [63:0] a1,
                         input logic [3:0] c, input logic [5:0] ad);
        valid_in = v;
        d0 = a0;
        d1 = a1;
        ctl = c;
        adr = ad;
    endtask

    task automatic apply_reset(input int n, input string tag);
        rst_n = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        sb.delete();
        chk({tag, " n_d0_zero"},  64'(n_d0),  64'd0);
        chk({tag, " n_d1_zero"},  64'(n_d1),  64'd0);
        chk({tag, " n_adr_zero"}, 64'(n_adr), 64'd0);
        chk({tag, " w_d0_zero"},  w_d0,       64'd0);
        chk({tag, " w_d1_zero"},  w_d1,       64'd0);
        chk({tag, " w_adr_zero"}, 64'(w_adr), 64'd0);
        check_outputs(tag);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        rdy_in = 1'b1;
        drive(1'b1, 64'hDEADBEEF, 64'hDEADBEEF, 4'hF, 6'h3F);
        #1;
        apply_reset(2, "reset");

        // Streaming at full rate, first push straight out of reset.
        drive(1'b1, 64'hFFFF_0000_1234_5678, 64'd0, 4'b0001, 6'd7);
        cycle("stream0");
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 64'hFFFF_0000_1234_5678 ^ 64'(i), 64'(i), 4'b0001, 6'(7 + i));
            cycle("stream");
        end
        drive(1'b0, 64'h0, 64'h0, 4'b0, 6'd0);
        cycle("stream_drain");
        cycle("stream_idle");

        // Back-pressure: fill both entries, offer C while full, then release.
        rdy_in = 1'b0;
        drive(1'b1, 64'hA0, 64'h10, 4'b0001, 6'd1);
        cycle("bp_pushA");
        drive(1'b1, 64'hB0, 64'h20, 4'b0001, 6'd2);
        cycle("bp_pushB");
        drive(1'b1, 64'hC0, 64'h30, 4'b0101, 6'd3);
        cycle("bp_full0");
        cycle("bp_full1");
        cycle("bp_full2");
        rdy_in = 1'b1;
        cycle("bp_release0");
        cycle("bp_release1");
        drive(1'b0, 64'h0, 64'h0, 4'b0, 6'd0);
        cycle("bp_drain0");
        cycle("bp_drain1");
        cycle("bp_idle");

        // Flush while full, coincident with a push of D and a ready head.
        rdy_in = 1'b0;
        drive(1'b1, 64'h1, 64'h11, 4'b0011, 6'd12);
        cycle("fl_push0");
        drive(1'b1, 64'h2, 64'h22, 4'b0011, 6'd13);
        cycle("fl_push1");
        drive(1'b1, 64'hD0, 64'hDD, 4'b0011, 6'd14);
        rdy_in = 1'b1;
        flush = 1'b1;
        cycle("fl_flush");
        flush = 1'b0;
        drive(1'b0, 64'h0, 64'h0, 4'b0, 6'd0);
        cycle("fl_after0");
        cycle("fl_after1");

        // Bubble gating after a RegWrite|MemtoReg entry drains.
        drive(1'b1, 64'h55, 64'h66, 4'b0011, 6'd20);
        cycle("bub_push");
        drive(1'b0, 64'h0, 64'h0, 4'b0011, 6'd0);
        cycle("bub_pop");
        cycle("bub_idle0");
        cycle("bub_idle1");

        // Reset with both entries held.
        rdy_in = 1'b0;
        drive(1'b1, 64'h77, 64'h88, 4'b0011, 6'd21);
        cycle("mr_push0");
        drive(1'b1, 64'h99, 64'hAA, 4'b0011, 6'd22);
        cycle("mr_push1");
        apply_reset(1, "mid_reset");
        rdy_in = 1'b1;
        drive(1'b0, 64'h0, 64'h0, 4'b0, 6'd0);
        cycle("mr_idle");
        cycle("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
